// File: rtl/fma_pkg.sv
// Shared types and constants for the FMA post-round stage (result kinds, flag indices, canonical NaN).
// Widths come from `NE/`NF and default to fma16 (5/10) when no shared header has set them.
`ifndef NE
`define NE 5
`endif
`ifndef NF
`define NF 10
`endif

package fma_pkg;
    localparam int RW = `NE + `NF + 1;

    typedef enum logic [1:0] {
        K_NORMAL = 2'd0,
        K_QNAN   = 2'd1,
        K_INF    = 2'd2,
        K_ZERO   = 2'd3
    } kind_e;

    localparam int FLG_NV = 3;
    localparam int FLG_OF = 2;
    localparam int FLG_UF = 1;
    localparam int FLG_NX = 0;

    // Positive quiet NaN: exponent all-ones, only the fraction MSB set.
    localparam logic [RW-1:0] QNAN_C = {1'b0, {`NE{1'b1}}, 1'b1, {(`NF-1){1'b0}}};

    typedef struct packed {
        logic [RW-1:0] result;
        logic [3:0]    flags;
    } entry_t;
endpackage

// File: rtl/fma_pack.sv
// Combinational packing of rounded fields into an IEEE word plus {NV,OF,UF,NX} flags.
// Latency 0; no flow control of its own.
`ifndef NE
`define NE 5
`endif
`ifndef NF
`define NF 10
`endif

module fma_pack
    import fma_pkg::*;
(
    input  logic [1:0]    kind_i,
    input  logic          sign_i,
    input  logic [`NE-1:0] exp_i,
    input  logic [`NF-1:0] fract_i,
    input  logic          round_overflow_i,
    input  logic          inexact_i,
    input  logic          underflow_i,
    input  logic          invalid_i,
    output logic [RW-1:0] result_o,
    output logic [3:0]    flags_o
);
    always_comb begin
        result_o         = {sign_i, exp_i, fract_i};
        flags_o          = '0;
        flags_o[FLG_NV]  = invalid_i;
        flags_o[FLG_OF]  = round_overflow_i;
        flags_o[FLG_UF]  = underflow_i & inexact_i;
        flags_o[FLG_NX]  = inexact_i | round_overflow_i;
        case (kind_e'(kind_i))
            K_QNAN: begin
                // A NaN result carries only the invalid indication.
                result_o        = QNAN_C;
                flags_o[FLG_OF] = 1'b0;
                flags_o[FLG_UF] = 1'b0;
                flags_o[FLG_NX] = 1'b0;
            end
            K_INF:   result_o = {sign_i, {`NE{1'b1}}, {`NF{1'b0}}};
            K_ZERO:  result_o = {sign_i, {`NE{1'b0}}, {`NF{1'b0}}};
            default: result_o = {sign_i, exp_i, fract_i};
        endcase
    end
endmodule

// File: rtl/fma_post.sv
// FMA post-round stage: pack + 2-entry in-order output buffer; optional sticky flags via FMA_FLAG_ACCUM_EN.
// Latency 1 cycle from input transfer to out_valid when empty; in_ready drops only when both entries are full.
`ifndef NE
`define NE 5
`endif
`ifndef NF
`define NF 10
`endif

module fma_post
    import fma_pkg::*;
(
    input  logic           clk,
    input  logic           reset_n,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [1:0]     in_kind,
    input  logic           r_sign,
    input  logic [`NE-1:0] r_exp,
    input  logic [`NF-1:0] r_fract,
    input  logic           round_overflow,
    input  logic           inexact,
    input  logic           underflow,
    input  logic           invalid,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [RW-1:0]  result,
    output logic [3:0]     flags,
    output logic [3:0]     fflags,
    input  logic           fflags_clr
);
    logic [RW-1:0] pk_result;
    logic [3:0]    pk_flags;

    fma_pack u_pack (
        .kind_i           (in_kind),
        .sign_i           (r_sign),
        .exp_i            (r_exp),
        .fract_i          (r_fract),
        .round_overflow_i (round_overflow),
        .inexact_i        (inexact),
        .underflow_i      (underflow),
        .invalid_i        (invalid),
        .result_o         (pk_result),
        .flags_o          (pk_flags)
    );

    entry_t     mem_q [2];
    logic       wr_q;
    logic       rd_q;
    logic [1:0] cnt_q;
    logic       push;
    logic       pop;

    // in_ready depends on registered occupancy only, so out_ready never reaches it.
    assign in_ready  = (cnt_q != 2'd2);
    assign out_valid = (cnt_q != 2'd0);
    assign push      = in_valid & in_ready;
    assign pop       = out_valid & out_ready;
    assign result    = mem_q[rd_q].result;
    assign flags     = mem_q[rd_q].flags;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mem_q[0] <= '0;
            mem_q[1] <= '0;
            wr_q     <= 1'b0;
            rd_q     <= 1'b0;
            cnt_q    <= 2'd0;
        end else begin
            if (push) begin
                mem_q[wr_q] <= '{result: pk_result, flags: pk_flags};
                wr_q        <= ~wr_q;
            end
            if (pop) rd_q <= ~rd_q;
            case ({push, pop})
                2'b10:   cnt_q <= cnt_q + 2'd1;
                2'b01:   cnt_q <= cnt_q - 2'd1;
                default: cnt_q <= cnt_q;
            endcase
        end
    end

`ifdef FMA_FLAG_ACCUM_EN
    logic [3:0] fflags_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            fflags_q <= '0;
        end else if (fflags_clr) begin
            fflags_q <= pop ? flags : 4'b0000;
        end else if (pop) begin
            fflags_q <= fflags_q | flags;
        end
    end

    assign fflags = fflags_q;
`else
    logic unused_fflags_clr;
    assign unused_fflags_clr = fflags_clr;
    assign fflags            = 4'b0000;
`endif
endmodule

// File: tb/tb_fma_post.sv
// Directed bench for fma_post: packing, flags, 2-entry buffering, reset and optional flag accrual.
`ifndef NE
`define NE 5
`endif
`ifndef NF
`define NF 10
`endif

module tb_fma_post;
    import fma_pkg::*;

`ifdef FMA_FLAG_ACCUM_EN
    localparam bit ACC = 1'b1;
`else
    localparam bit ACC = 1'b0;
`endif

    logic           clk = 1'b0;
    logic           reset_n;
    logic           in_valid;
    logic           in_ready;
    logic [1:0]     in_kind;
    logic           r_sign;
    logic [`NE-1:0] r_exp;
    logic [`NF-1:0] r_fract;
    logic           round_overflow, inexact, underflow, invalid;
    logic           out_valid;
    logic           out_ready;
    logic [RW-1:0]  result;
    logic [3:0]     flags;
    logic [3:0]     fflags;
    logic           fflags_clr;

    int n_vec = 0;
    int n_bad = 0;

    fma_post dut (
        .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_kind(in_kind), .r_sign(r_sign), .r_exp(r_exp), .r_fract(r_fract),
        .round_overflow(round_overflow), .inexact(inexact), .underflow(underflow),
        .invalid(invalid), .out_valid(out_valid), .out_ready(out_ready),
        .result(result), .flags(flags), .fflags(fflags), .fflags_clr(fflags_clr)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        assert (got === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drive one offer; the 16-bit word is split into sign/exp/fract.
    task automatic offer(input logic [1:0] k, input logic [RW-1:0] w,
                         input logic ovf, input logic inx, input logic unf, input logic inv);
        in_valid       = 1'b1;
        in_kind        = k;
        {r_sign, r_exp, r_fract} = w;
        round_overflow = ovf;
        inexact        = inx;
        underflow      = unf;
        invalid        = inv;
    endtask

    initial begin
        reset_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; fflags_clr = 1'b0;
        offer(K_NORMAL, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0);
        in_valid = 1'b0;
        #2;
        chk("rst_out_valid", 32'(out_valid), 32'h0);
        chk("rst_in_ready",  32'(in_ready),  32'h1);
        chk("rst_result",    32'(result),    32'h0);
        chk("rst_flags",     32'(flags),     32'h0);
        chk("rst_fflags",    32'(fflags),    32'h0);
        @(negedge clk); reset_n = 1'b1;

        // NORMAL 1.0: transfer on the first edge after reset release
        offer(K_NORMAL, 16'h3C00, 1'b0, 1'b0, 1'b0, 1'b0);
        tick(); in_valid = 1'b0;
        chk("norm_valid",  32'(out_valid), 32'h1);
        chk("norm_result", 32'(result),    32'h3C00);
        chk("norm_flags",  32'(flags),     32'h0);
        out_ready = 1'b1; tick(); out_ready = 1'b0;
        chk("norm_drained", 32'(out_valid), 32'h0);

        // Ignored fields while in_valid is low
        offer(K_INF, 16'h1111, 1'b1, 1'b1, 1'b1, 1'b1); in_valid = 1'b0;
        tick();
        chk("idle_no_entry", 32'(out_valid), 32'h0);

        // NORMAL inexact -> NX only
        offer(K_NORMAL, 16'h4248, 1'b0, 1'b1, 1'b0, 1'b0);
        tick(); in_valid = 1'b0;
        chk("nx_result", 32'(result), 32'h4248);
        chk("nx_flags",  32'(flags),  32'b0001);
        out_ready = 1'b1; tick(); out_ready = 1'b0;
        chk("nx_fflags", 32'(fflags), ACC ? 32'b0001 : 32'h0);

        // INF with junk fields: sign kept, exp/fract forced
        offer(K_INF, 16'h8D55, 1'b1, 1'b1, 1'b0, 1'b0);
        tick(); in_valid = 1'b0;
        chk("inf_result", 32'(result), 32'hFC00);
        chk("inf_flags",  32'(flags),  32'b0101);
        out_ready = 1'b1; tick(); out_ready = 1'b0;
        chk("inf_fflags", 32'(fflags), ACC ? 32'b0101 : 32'h0);

        // QNAN suppresses OF/UF/NX; popped together with clr
        offer(K_QNAN, 16'hFFFF, 1'b1, 1'b1, 1'b1, 1'b1);
        tick(); in_valid = 1'b0;
        chk("nan_result", 32'(result), 32'h7E00);
        chk("nan_flags",  32'(flags),  32'b1000);
        out_ready = 1'b1; fflags_clr = 1'b1; tick(); out_ready = 1'b0; fflags_clr = 1'b0;
        chk("nan_clr_fflags", 32'(fflags), ACC ? 32'b1000 : 32'h0);

        // ZERO, underflow & inexact -> UF|NX; underflow alone would give UF=0
        offer(K_ZERO, 16'hABCD, 1'b0, 1'b1, 1'b1, 1'b0);
        tick();
        chk("zero_result", 32'(result), 32'h8000);
        chk("zero_flags",  32'(flags),  32'b0011);
        // Simultaneous push/pop with one entry resident
        offer(K_NORMAL, 16'h2A01, 1'b0, 1'b0, 1'b1, 1'b0);
        out_ready = 1'b1; tick(); in_valid = 1'b0;
        chk("sim_valid",  32'(out_valid), 32'h1);
        chk("sim_result", 32'(result),    32'h2A01);
        chk("sim_flags",  32'(flags),     32'b0000);
        chk("sim_fflags", 32'(fflags),    ACC ? 32'b1011 : 32'h0);
        tick(); out_ready = 1'b0;
        chk("sim_drained", 32'(out_valid), 32'h0);

        // Standalone clear
        fflags_clr = 1'b1; tick(); fflags_clr = 1'b0;
        chk("clr_fflags", 32'(fflags), 32'h0);

        // Back-to-back A,B,C with downstream stalled
        offer(K_NORMAL, 16'h1234, 1'b0, 1'b0, 1'b0, 1'b0); tick();
        chk("abc_rdy_after_a", 32'(in_ready), 32'h1);
        offer(K_NORMAL, 16'h5678, 1'b0, 1'b0, 1'b0, 1'b0); tick();
        chk("abc_rdy_full", 32'(in_ready), 32'h0);
        offer(K_NORMAL, 16'h9ABC, 1'b0, 1'b0, 1'b0, 1'b0); tick();
        chk("abc_c_held",   32'(in_ready), 32'h0);
        chk("abc_a_stable", 32'(result),   32'h1234);
        out_ready = 1'b1; tick();
        chk("abc_out_b", 32'(result),   32'h5678);
        chk("abc_rdy_b", 32'(in_ready), 32'h1);
        tick(); in_valid = 1'b0;
        chk("abc_out_c",   32'(result),    32'h9ABC);
        chk("abc_valid_c", 32'(out_valid), 32'h1);
        tick(); out_ready = 1'b0;
        chk("abc_empty", 32'(out_valid), 32'h0);

        // Async reset with both entries full and accrued flags pending
        offer(K_NORMAL, 16'h0101, 1'b0, 1'b1, 1'b0, 1'b0);
        out_ready = 1'b1; tick(); tick(); out_ready = 1'b0;
        chk("pre_rst_fflags", 32'(fflags), ACC ? 32'b0001 : 32'h0);
        tick(); in_valid = 1'b0;
        chk("pre_rst_full", 32'(in_ready), 32'h0);
        #2 reset_n = 1'b0; #1;
        chk("arst_out_valid", 32'(out_valid), 32'h0);
        chk("arst_in_ready",  32'(in_ready),  32'h1);
        chk("arst_fflags",    32'(fflags),    32'h0);
        chk("arst_result",    32'(result),    32'h0);
        @(negedge clk); reset_n = 1'b1; out_ready = 1'b1;
        tick(); tick();
        chk("no_stale", 32'(out_valid), 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
